// File: rtl/jump_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage jump/branch hazard unit:
// forwarding mux selects and registered stall-cause codes.
package jump_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_LONG  = 2'b11;

    typedef enum logic [1:0] {
        CAUSE_RUN  = 2'd0,
        CAUSE_RAW  = 2'd1,
        CAUSE_LONG = 2'd2,
        CAUSE_FRZ  = 2'd3
    } cause_e;

endpackage

// File: rtl/jump_hazard_ctrl_cmp.sv
// Per-operand compare: RAW/long-busy detection and forward select
// for one ID-stage source register.
module hazard_cmp
    import jump_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                   srcUsed,
    input  logic [REG_AW-1:0]      srcReg,
    input  logic [2**REG_AW-1:0]   busy,
    input  logic                   idexWrite,
    input  logic [REG_AW-1:0]      idexDst,
    input  logic                   exmemWrite,
    input  logic                   exmemRead,
    input  logic [REG_AW-1:0]      exmemDst,
    input  logic                   memwbWrite,
    input  logic [REG_AW-1:0]      memwbDst,
    input  logic                   longWbValid,
    input  logic [REG_AW-1:0]      longWbDst,
    output logic                   rawHaz,
    output logic                   longHaz,
    output logic [1:0]             fwd
);

    logic live;
    logic longHit;
    logic exmemHit;
    logic memwbHit;

    // $0 is hardwired, so it never needs a stall or a bypass
    assign live     = srcUsed && (srcReg != '0);
    assign longHit  = longWbValid && (longWbDst == srcReg);
    assign exmemHit = exmemWrite && !exmemRead && (exmemDst == srcReg);
    assign memwbHit = memwbWrite && (memwbDst == srcReg);

    assign rawHaz = live &&
        ((idexWrite && (idexDst == srcReg)) ||
         (exmemRead && (exmemDst == srcReg)));

    assign longHaz = live && busy[srcReg] && !longHit;

    always_comb begin
        fwd = FWD_RF;
        if (live) begin
            if (longHit)
                fwd = FWD_LONG;
            else if (exmemHit)
                fwd = FWD_EXMEM;
            else if (memwbHit)
                fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/jump_hazard_ctrl.sv
// ID-stage hazard control for early-resolved operands with a
// long-latency busy scoreboard, stall-cause FSM and hang watchdog.
module jump_hazard_ctrl
    import jump_hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_stall,
    input  logic                      id_valid,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_reg,
    input  logic                      id_issue_long,
    input  logic [REG_AW-1:0]         id_dst_reg,
    input  logic                      idex_regwrite,
    input  logic [REG_AW-1:0]         idex_dst,
    input  logic                      exmem_regwrite,
    input  logic                      exmem_memread,
    input  logic [REG_AW-1:0]         exmem_dst,
    input  logic                      memwb_regwrite,
    input  logic [REG_AW-1:0]         memwb_dst,
    input  logic                      long_wb_valid,
    input  logic [REG_AW-1:0]         long_wb_dst,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      flush_idex,
    output logic [1:0]                stall_cause,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic                      hang_err
);

    localparam logic [CNT_W-1:0] HANG_AT = CNT_W'(TIMEOUT - 1);

    logic [2**REG_AW-1:0] busy;
    logic [2**REG_AW-1:0] busyNext;
    logic [NUM_SRC-1:0]   rawVec;
    logic [NUM_SRC-1:0]   longVec;
    logic [2*NUM_SRC-1:0] fwdVec;
    logic                 rawAny;
    logic                 wawHaz;
    logic                 longAny;
    logic                 accept;
    cause_e               causeQ;
    cause_e               causeD;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
        hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
            .srcUsed     (id_valid && id_src_used[i]),
            .srcReg      (id_src_reg[i*REG_AW +: REG_AW]),
            .busy        (busy),
            .idexWrite   (idex_regwrite),
            .idexDst     (idex_dst),
            .exmemWrite  (exmem_regwrite),
            .exmemRead   (exmem_memread),
            .exmemDst    (exmem_dst),
            .memwbWrite  (memwb_regwrite),
            .memwbDst    (memwb_dst),
            .longWbValid (long_wb_valid),
            .longWbDst   (long_wb_dst),
            .rawHaz      (rawVec[i]),
            .longHaz     (longVec[i]),
            .fwd         (fwdVec[2*i +: 2])
        );
    end

    assign rawAny  = |rawVec;
    assign wawHaz  = id_valid && id_issue_long &&
                     (id_dst_reg != '0) && busy[id_dst_reg];
    assign longAny = (|longVec) || wawHaz;

    // Outputs are forced low in reset so the pipeline releases at once
    assign stall      = rst_n && (rawAny || longAny || mem_stall);
    assign flush_idex = rst_n && (rawAny || longAny) && !mem_stall;
    assign fwd_sel    = rst_n ? fwdVec : '0;
    assign accept     = id_valid && id_issue_long && !stall;

    // Clear first so a same-cycle issue to that register wins
    always_comb begin
        busyNext = busy;
        if (long_wb_valid)
            busyNext[long_wb_dst] = 1'b0;
        if (accept)
            busyNext[id_dst_reg] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_comb begin
        causeD = CAUSE_RUN;
        if (mem_stall)
            causeD = CAUSE_FRZ;
        else if (longAny)
            causeD = CAUSE_LONG;
        else if (rawAny)
            causeD = CAUSE_RAW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            causeQ <= CAUSE_RUN;
        end else begin
            busy   <= busyNext;
            causeQ <= causeD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            hang_err  <= 1'b0;
        end else begin
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall && (stall_cnt == HANG_AT))
                hang_err <= 1'b1;
        end
    end

    assign stall_cause = causeQ;

endmodule

// File: tb/tb_jump_hazard_ctrl.sv
// Directed bench for jump_hazard_ctrl: forwarding, RAW/long stalls,
// freeze, $0 immunity, scoreboard set-wins and the hang watchdog.
module tb_jump_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_stall;
    logic       id_valid;
    logic [1:0] id_src_used;
    logic [9:0] id_src_reg;
    logic       id_issue_long;
    logic [4:0] id_dst_reg;
    logic       idex_regwrite;
    logic [4:0] idex_dst;
    logic       exmem_regwrite;
    logic       exmem_memread;
    logic [4:0] exmem_dst;
    logic       memwb_regwrite;
    logic [4:0] memwb_dst;
    logic       long_wb_valid;
    logic [4:0] long_wb_dst;
    logic [3:0] fwd_sel;
    logic       stall;
    logic       flush_idex;
    logic [1:0] stall_cause;
    logic [7:0] stall_cnt;
    logic       hang_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jump_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_stall      (mem_stall),
        .id_valid       (id_valid),
        .id_src_used    (id_src_used),
        .id_src_reg     (id_src_reg),
        .id_issue_long  (id_issue_long),
        .id_dst_reg     (id_dst_reg),
        .idex_regwrite  (idex_regwrite),
        .idex_dst       (idex_dst),
        .exmem_regwrite (exmem_regwrite),
        .exmem_memread  (exmem_memread),
        .exmem_dst      (exmem_dst),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dst      (memwb_dst),
        .long_wb_valid  (long_wb_valid),
        .long_wb_dst    (long_wb_dst),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .flush_idex     (flush_idex),
        .stall_cause    (stall_cause),
        .stall_cnt      (stall_cnt),
        .hang_err       (hang_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        mem_stall = 0; id_valid = 0; id_src_used = 0; id_src_reg = 0;
        id_issue_long = 0; id_dst_reg = 0;
        idex_regwrite = 0; idex_dst = 0;
        exmem_regwrite = 0; exmem_memread = 0; exmem_dst = 0;
        memwb_regwrite = 0; memwb_dst = 0;
        long_wb_valid = 0; long_wb_dst = 0;
    endtask

    // Advance one cycle, land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_cause", stall_cause, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_hang", hang_err, 0);
        rst_n = 1;
        tick();

        // jr $5, ID/EX writes $5
        id_valid = 1; id_src_used = 2'b01; id_src_reg = {5'd0, 5'd5};
        idex_regwrite = 1; idex_dst = 5; settle();
        chk("jr_raw_stall", stall, 1);
        chk("jr_raw_flush", flush_idex, 1);
        tick();
        chk("jr_raw_cause", stall_cause, 1);
        chk("jr_raw_cnt", stall_cnt, 1);
        idex_regwrite = 0; exmem_regwrite = 1; exmem_dst = 5; settle();
        chk("jr_fwd_exmem", fwd_sel, 4'b0001);
        chk("jr_fwd_stall", stall, 0);
        tick();
        chk("jr_cause_run", stall_cause, 0);
        chk("jr_cnt_zero", stall_cnt, 0);
        clr();

        // beq $3,$4 with EX/MEM load to $4
        id_valid = 1; id_src_used = 2'b11; id_src_reg = {5'd4, 5'd3};
        exmem_regwrite = 1; exmem_memread = 1; exmem_dst = 4; settle();
        chk("beq_load_stall", stall, 1);
        chk("beq_load_flush", flush_idex, 1);
        tick();
        exmem_regwrite = 0; exmem_memread = 0;
        memwb_regwrite = 1; memwb_dst = 4; settle();
        chk("beq_fwd_memwb", fwd_sel, 4'b1000);
        chk("beq_nostall", stall, 0);
        tick();
        clr();

        // mult $8 accepted, jr $8 three cycles later
        id_valid = 1; id_issue_long = 1; id_dst_reg = 8; settle();
        chk("mult_accept", stall, 0);
        tick();
        clr(); tick(); tick();
        id_valid = 1; id_src_used = 2'b01; id_src_reg = {5'd0, 5'd8};
        settle();
        chk("long_stall", stall, 1);
        chk("long_flush", flush_idex, 1);
        tick();
        chk("long_cause", stall_cause, 2);
        chk("long_stall2", stall, 1);
        tick(); tick();
        chk("long_cnt", stall_cnt, 3);
        long_wb_valid = 1; long_wb_dst = 8; settle();
        chk("long_wb_stall", stall, 0);
        chk("long_wb_fwd", fwd_sel, 4'b0011);
        tick();
        long_wb_valid = 0; settle();
        chk("long_cleared", stall, 0);
        chk("long_cleared_fwd", fwd_sel, 4'b0000);
        tick();
        clr();

        // Same-cycle set and clear of $11: set wins
        id_valid = 1; id_issue_long = 1; id_dst_reg = 11;
        long_wb_valid = 1; long_wb_dst = 11; settle();
        chk("setwin_accept", stall, 0);
        tick();
        clr();
        id_valid = 1; id_src_used = 2'b10; id_src_reg = {5'd11, 5'd0};
        settle();
        chk("setwin_busy", stall, 1);
        clr();
        id_valid = 1; id_issue_long = 1; id_dst_reg = 11; settle();
        chk("waw_stall", stall, 1);
        chk("waw_flush", flush_idex, 1);
        tick();
        clr();
        long_wb_valid = 1; long_wb_dst = 11; tick();
        clr(); tick();

        // RAW coinciding with a cache freeze
        id_valid = 1; id_src_used = 2'b01; id_src_reg = {5'd0, 5'd5};
        idex_regwrite = 1; idex_dst = 5; mem_stall = 1; settle();
        chk("frz_stall", stall, 1);
        chk("frz_noflush", flush_idex, 0);
        tick();
        chk("frz_cause", stall_cause, 3);
        clr(); tick();
        chk("frz_exit_cause", stall_cause, 0);

        // $0 sources with every stage writing $0
        id_valid = 1; id_src_used = 2'b11; id_src_reg = 10'd0;
        idex_regwrite = 1; exmem_regwrite = 1; exmem_memread = 1;
        memwb_regwrite = 1; long_wb_valid = 1; settle();
        chk("zero_stall", stall, 0);
        chk("zero_fwd", fwd_sel, 4'b0000);
        tick();
        clr();

        // id_valid low masks an otherwise live hazard
        id_src_used = 2'b01; id_src_reg = {5'd0, 5'd5};
        idex_regwrite = 1; idex_dst = 5; settle();
        chk("novalid_stall", stall, 0);
        tick();
        clr();

        // Hang watchdog on $9 that never writes back
        id_valid = 1; id_issue_long = 1; id_dst_reg = 9; tick();
        clr();
        id_valid = 1; id_src_used = 2'b01; id_src_reg = {5'd0, 5'd9};
        settle();
        chk("hang_stall", stall, 1);
        repeat (199) tick();
        chk("hang_cnt199", stall_cnt, 199);
        chk("hang_not_yet", hang_err, 0);
        tick();
        chk("hang_set", hang_err, 1);
        repeat (60) tick();
        chk("hang_sat", stall_cnt, 255);
        chk("hang_sticky", hang_err, 1);
        #2;
        rst_n = 0; #1;
        chk("arst_stall", stall, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_hang", hang_err, 0);
        chk("arst_cause", stall_cause, 0);
        tick();
        rst_n = 1; tick();
        settle();
        chk("arst_busy_clr", stall, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
